// File: rtl/cache2way_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cache2way_wb_ctrl_if
// Description : CPU request/response and backing-memory handshake bundle for
//               the 2-way write-back cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache2way_wb_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    // CPU side
    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    // Backing-memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    // Statistics
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    // Cache controller view
    modport slave (
        input  req_valid, req_wren, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_hit, resp_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );

    // Environment view (CPU plus memory)
    modport master (
        output req_valid, req_wren, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_hit, resp_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/cache2way_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache2way_wb_ctrl
// Description : 2-way set-associative, write-back, write-allocate data cache
//               controller with per-set LRU bit, miss FSM (optional dirty
//               write-back then refill) and saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cache2way_wb_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 2,
    parameter int CNT_W   = 8
) (
    input  logic                clock,
    input  logic                resetn,
    cache2way_wb_ctrl_if.slave  bus
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int SETS  = 2 ** INDEX_W;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_RESPOND   = 3'd4
    } state_t;

    state_t r_state;

    // Line storage: data and tags are never cleared, only the status bits are
    logic [DATA_W-1:0]  r_data  [2][SETS];
    logic [TAG_W-1:0]   r_tag   [2][SETS];
    logic [SETS-1:0]    r_valid [2];
    logic [SETS-1:0]    r_dirty [2];
    logic [SETS-1:0]    r_lru;

    // Latched request and chosen victim way
    logic [TAG_W-1:0]   r_req_tag;
    logic [INDEX_W-1:0] r_req_set;
    logic               r_req_wren;
    logic [DATA_W-1:0]  r_req_wdata;
    logic               r_victim;

    // Registered outputs
    logic               r_req_ready;
    logic               r_resp_valid;
    logic               r_resp_hit;
    logic [DATA_W-1:0]  r_resp_rdata;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [CNT_W-1:0]   r_hit_count;
    logic [CNT_W-1:0]   r_miss_count;

    logic w_hit0;
    logic w_hit1;
    logic w_hit;
    logic w_hit_way;
    logic w_victim;

    assign w_hit0    = r_valid[0][r_req_set] && (r_tag[0][r_req_set] == r_req_tag);
    assign w_hit1    = r_valid[1][r_req_set] && (r_tag[1][r_req_set] == r_req_tag);
    assign w_hit     = w_hit0 | w_hit1;
    assign w_hit_way = ~w_hit0;
    // Fill an empty way first (way0 preferred); otherwise evict the LRU way
    assign w_victim  = !r_valid[0][r_req_set] ? 1'b0 :
                       !r_valid[1][r_req_set] ? 1'b1 : r_lru[r_req_set];

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_hit   = r_resp_hit;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;

    // Request FSM, line/status updates and all registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_valid[0]   <= '0;
            r_valid[1]   <= '0;
            r_dirty[0]   <= '0;
            r_dirty[1]   <= '0;
            r_lru        <= '0;
            r_req_tag    <= '0;
            r_req_set    <= '0;
            r_req_wren   <= 1'b0;
            r_req_wdata  <= '0;
            r_victim     <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_req_tag   <= bus.req_addr[ADDR_W-1:INDEX_W];
                        r_req_set   <= bus.req_addr[INDEX_W-1:0];
                        r_req_wren  <= bus.req_wren;
                        r_req_wdata <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_req_wren) begin
                            r_data[w_hit_way][r_req_set]  <= r_req_wdata;
                            r_dirty[w_hit_way][r_req_set] <= 1'b1;
                            r_resp_rdata                  <= r_req_wdata;
                        end else begin
                            r_resp_rdata <= r_data[w_hit_way][r_req_set];
                        end
                        r_lru[r_req_set] <= ~w_hit_way;
                        r_resp_valid     <= 1'b1;
                        r_resp_hit       <= 1'b1;
                        if (~&r_hit_count) begin
                            r_hit_count <= r_hit_count + C_CNT_ONE;
                        end
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_victim  <= w_victim;
                        r_mem_req <= 1'b1;
                        if (r_valid[w_victim][r_req_set] && r_dirty[w_victim][r_req_set]) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_victim][r_req_set], r_req_set};
                            r_mem_wdata <= r_data[w_victim][r_req_set];
                            r_state     <= S_WRITEBACK;
                        end else begin
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {r_req_tag, r_req_set};
                            r_state    <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    // Dropping mem_req here gives the idle cycle before the refill
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {r_req_tag, r_req_set};
                    end else if (bus.mem_ack) begin
                        r_mem_req                    <= 1'b0;
                        r_data[r_victim][r_req_set]  <= r_req_wren ? r_req_wdata : bus.mem_rdata;
                        r_tag[r_victim][r_req_set]   <= r_req_tag;
                        r_valid[r_victim][r_req_set] <= 1'b1;
                        r_dirty[r_victim][r_req_set] <= r_req_wren;
                        r_lru[r_req_set]             <= ~r_victim;
                        r_state                      <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= 1'b0;
                    r_resp_rdata <= r_data[r_victim][r_req_set];
                    if (~&r_miss_count) begin
                        r_miss_count <= r_miss_count + C_CNT_ONE;
                    end
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_mem_req   <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache2way_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache2way_wb_ctrl
// Description : Self-checking bench for cache2way_wb_ctrl. A memory-semantics
//               model (last written value per address) predicts read data and
//               an LRU-ordered list of resident lines predicts hits, misses
//               and memory traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache2way_wb_ctrl;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int INDEX_W = 2;
    localparam int CNT_W   = 2;
    localparam int CMAX    = 2 ** CNT_W - 1;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    cache2way_wb_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    cache2way_wb_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } mtxn_t;

    typedef struct {
        logic [4:0] addr;
        logic       dirty;
    } line_t;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] bmem [32];      // backing memory contents
    logic [7:0] gold [32];      // value a CPU read must return
    mtxn_t      mlog [$];       // completed memory transactions
    line_t      resident [$];   // cached lines, least recently used first
    int         exp_hits = 0;
    int         exp_miss = 0;
    bit         ack_hold = 1'b0;
    int         wait_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Backing memory: acks after 0..3 wait cycles; read acks can be withheld
    initial begin : memory_model
        mtxn_t t;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clock);
            bus.mem_ack = 1'b0;
            if (!resetn) begin
                wait_cnt = 0;
            end else if (bus.mem_req === 1'b1 && !(ack_hold && bus.mem_we === 1'b0)) begin
                if (wait_cnt == 0) begin
                    t.we   = bus.mem_we;
                    t.addr = bus.mem_addr;
                    t.data = bus.mem_wdata;
                    if (bus.mem_we) begin
                        bmem[bus.mem_addr] = bus.mem_wdata;
                    end else begin
                        bus.mem_rdata = bmem[bus.mem_addr];
                    end
                    bus.mem_ack = 1'b1;
                    mlog.push_back(t);
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    function automatic bit is_resident(input logic [4:0] a);
        for (int i = 0; i < resident.size(); i++) begin
            if (resident[i].addr == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_req(input logic wr, input logic [4:0] a, input logic [7:0] wd);
        int         idx;
        int         cnt;
        int         vi;
        int         cyc;
        int         guard;
        bit         got;
        bit         exp_hit;
        line_t      l;
        mtxn_t      e;
        mtxn_t      exp_q [$];
        logic [7:0] exp_rdata;

        // Predict the outcome from the resident-line list
        idx = -1; cnt = 0; vi = -1;
        for (int i = 0; i < resident.size(); i++) begin
            if (resident[i].addr == a) idx = i;
        end
        if (idx >= 0) begin
            exp_hit = 1'b1;
            l = resident[idx];
            resident.delete(idx);
            l.dirty = l.dirty | wr;
            resident.push_back(l);
            exp_hits = (exp_hits < CMAX) ? exp_hits + 1 : CMAX;
        end else begin
            exp_hit = 1'b0;
            for (int i = 0; i < resident.size(); i++) begin
                if (resident[i].addr[1:0] == a[1:0]) begin
                    cnt++;
                    if (vi < 0) vi = i;
                end
            end
            if (cnt == 2) begin
                if (resident[vi].dirty) begin
                    e.we = 1'b1; e.addr = resident[vi].addr; e.data = gold[resident[vi].addr];
                    exp_q.push_back(e);
                end
                resident.delete(vi);
            end
            e.we = 1'b0; e.addr = a; e.data = '0;
            exp_q.push_back(e);
            l.addr = a; l.dirty = wr;
            resident.push_back(l);
            exp_miss = (exp_miss < CMAX) ? exp_miss + 1 : CMAX;
        end
        exp_rdata = wr ? wd : gold[a];
        if (wr) gold[a] = wd;

        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk("req_ready_idle", bus.req_ready, 1);
        mlog.delete();
        bus.req_valid = 1'b1;
        bus.req_wren  = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(negedge clock);
        bus.req_valid = 1'b0;
        cyc = 1;
        chk("req_ready_busy", bus.req_ready, 0);
        // A request offered while busy must be ignored
        if ($urandom_range(0, 1) == 1) begin
            bus.req_valid = 1'b1;
            bus.req_wren  = 1'($urandom_range(0, 1));
            bus.req_addr  = 5'($urandom_range(0, 31));
            bus.req_wdata = 8'($urandom_range(0, 255));
        end
        got = 1'b0;
        while (!got && cyc < 100) begin
            if (bus.resp_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                @(negedge clock);
                bus.req_valid = 1'b0;
                cyc++;
            end
        end
        bus.req_valid = 1'b0;
        if (!got) begin
            chk("resp_timeout", 0, 1);
            return;
        end
        chk("resp_hit", bus.resp_hit, exp_hit);
        if (exp_hit) chk("hit_latency", cyc, 2);
        chk("resp_rdata", bus.resp_rdata, exp_rdata);
        chk("hit_count", bus.hit_count, exp_hits);
        chk("miss_count", bus.miss_count, exp_miss);
        chk("mem_txn_count", mlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mlog.size(); i++) begin
            chk("mem_we", mlog[i].we, exp_q[i].we);
            chk("mem_addr", mlog[i].addr, exp_q[i].addr);
            if (exp_q[i].we) chk("mem_wdata", mlog[i].data, exp_q[i].data);
        end
        @(negedge clock);
        chk("resp_single", bus.resp_valid, 0);
    endtask

    initial begin : stimulus
        logic [4:0] a;
        int         guard;

        bus.req_valid = 1'b0;
        bus.req_wren  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            bmem[i] = 8'($urandom_range(0, 255));
        end
        bmem[5'h0B] = 8'hA5;
        for (int i = 0; i < 32; i++) gold[i] = bmem[i];

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_hit", bus.resp_hit, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_hit_count", bus.hit_count, 0);
        chk("rst_miss_count", bus.miss_count, 0);
        resetn = 1'b1;
        @(negedge clock);

        // Cold miss then hit on 0x0B
        do_req(1'b0, 5'h0B, 8'h00);
        do_req(1'b0, 5'h0B, 8'h00);
        // LRU eviction within set 3
        do_req(1'b0, 5'h03, 8'h00);
        do_req(1'b0, 5'h07, 8'h00);
        do_req(1'b0, 5'h0B, 8'h00);
        do_req(1'b0, 5'h07, 8'h00);
        do_req(1'b0, 5'h03, 8'h00);
        // Dirty victim write-back in set 2
        do_req(1'b1, 5'h02, 8'h5A);
        do_req(1'b0, 5'h06, 8'h00);
        do_req(1'b0, 5'h0A, 8'h00);
        // Counter saturation
        repeat (5) do_req(1'b0, 5'h0A, 8'h00);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        end

        // Reset while a refill waits for its ack
        a = 5'h00;
        for (int i = 31; i >= 0; i--) begin
            if (!is_resident(5'(i))) a = 5'(i);
        end
        ack_hold = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_wren  = 1'b0;
        bus.req_addr  = a;
        @(negedge clock);
        bus.req_valid = 1'b0;
        guard = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b0) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        chk("refill_started", bus.mem_req, 1);
        #2 resetn = 1'b0;
        #1;
        chk("abort_mem_req", bus.mem_req, 0);
        chk("abort_req_ready", bus.req_ready, 1);
        chk("abort_hit_count", bus.hit_count, 0);
        chk("abort_miss_count", bus.miss_count, 0);
        @(negedge clock);
        resetn   = 1'b1;
        ack_hold = 1'b0;
        resident.delete();
        exp_hits = 0;
        exp_miss = 0;
        // Dirty lines were discarded, so memory is the reference again
        for (int i = 0; i < 32; i++) gold[i] = bmem[i];
        do_req(1'b0, a, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
